psum_row_accum: RTL and testbench

- Accumulates per-kernel-row convolution partial sums across the K rows of a kernel window.
- Sits upstream and downstream of the conv-kernel synchronous FIFO (25-bit, depth 61), which it uses as a one-row delay line. It pushes row-r psums into the FIFO and pops them back when row r+1 products arrive.
- After the last kernel row, the completed sums go to the output port instead of the FIFO.

---
 rtl/conv_pkg.sv | 33 +++
 rtl/psum_row_accum_if.sv | 42 ++++
 rtl/psum_row_accum_out_reg.sv | 37 +++
 rtl/psum_row_accum.sv | 109 ++++++++++
 tb/tb_psum_row_accum.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared conv datapath constants, row-phase encoding and
// the saturating psum adder.
package conv_pkg;

    localparam int DATA_W  = 25;
    localparam int IN_W    = 20;
    localparam int ROW_LEN = 61;
    localparam int K       = 3;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        PH_FIRST,
        PH_MID,
        PH_LAST
    } phase_e;

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Add with one guard bit; clamp when the guard and sign disagree.
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] == s[DATA_W-1]) begin
            return s[DATA_W-1:0];
        end
        return s[DATA_W] ? SAT_MIN : SAT_MAX;
    endfunction

endpackage

// File: rtl/psum_row_accum_if.sv
// Row-product input, delay-line FIFO and final-psum output
// bundle of the psum row accumulator.
interface psum_row_accum_if #(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int IN_W   = conv_pkg::IN_W
);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [IN_W-1:0]   in_data;

    logic                     fifo_wr_en;
    logic signed [DATA_W-1:0] fifo_din;
    logic                     fifo_full;
    logic                     fifo_rd_en;
    logic signed [DATA_W-1:0] fifo_dout;
    logic                     fifo_empty;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     row_done;

    modport slave (
        input  in_valid, in_data,
        input  fifo_full, fifo_dout, fifo_empty,
        input  out_ready,
        output in_ready,
        output fifo_wr_en, fifo_din, fifo_rd_en,
        output out_valid, out_data, row_done
    );

    modport master (
        output in_valid, in_data,
        output fifo_full, fifo_dout, fifo_empty,
        output out_ready,
        input  in_ready,
        input  fifo_wr_en, fifo_din, fifo_rd_en,
        input  out_valid, out_data, row_done
    );

endinterface

// File: rtl/psum_row_accum_out_reg.sv
// Valid/ready output register for completed psums; row_done
// pulses for one cycle alongside the load of a row's last column.
module psum_out_reg #(
    parameter int DATA_W = 25
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     last,
    input  logic                     ready,
    output logic                     can_load,
    output logic                     valid,
    output logic signed [DATA_W-1:0] data,
    output logic                     row_done
);

    assign can_load = !valid || ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            data     <= '0;
            row_done <= 1'b0;
        end else begin
            row_done <= 1'b0;
            if (load) begin
                valid    <= 1'b1;
                data     <= din;
                row_done <= last;
            end else if (ready) begin
                valid    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/psum_row_accum.sv
// Accumulates kernel-row partial sums, using the external FIFO as
// a one-row delay line; the last kernel row goes to the output.
module psum_row_accum #(
    parameter int DATA_W  = conv_pkg::DATA_W,
    parameter int IN_W    = conv_pkg::IN_W,
    parameter int ROW_LEN = conv_pkg::ROW_LEN,
    parameter int K       = conv_pkg::K,
    parameter int CNT_W   = conv_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    psum_row_accum_if.slave  bus
);

    import conv_pkg::*;

    localparam int RW = $clog2(K);

    logic [CNT_W-1:0]         col_cnt;
    logic [RW-1:0]            row_cnt;
    phase_e                   phase;
    logic                     col_wrap;
    logic                     accept;

    logic                     s1_valid;
    logic signed [IN_W-1:0]   s1_data;
    phase_e                   s1_phase;
    logic                     s1_last;
    logic                     s1_go;
    logic                     s1_to_fifo;
    logic                     s1_done;
    logic signed [DATA_W-1:0] s1_ext;
    logic signed [DATA_W-1:0] s1_sum;

    logic                     out_load;
    logic                     out_can_load;

    always_comb begin
        unique case (1'b1)
            (row_cnt == '0):        phase = PH_FIRST;
            (row_cnt == RW'(K-1)):  phase = PH_LAST;
            default:                phase = PH_MID;
        endcase
    end

    assign col_wrap = (col_cnt == CNT_W'(ROW_LEN-1));

    // Stage 1 consumes fifo_dout, which only moves on a pop, so
    // holding off accepts keeps the popped word stable under stall.
    assign s1_go      = s1_valid && !rst;
    assign s1_to_fifo = (s1_phase != PH_LAST);
    assign s1_ext     = {{(DATA_W-IN_W){s1_data[IN_W-1]}}, s1_data};
    assign s1_sum     = (s1_phase == PH_FIRST) ? s1_ext
                      : sat_add(s1_ext, bus.fifo_dout);
    assign s1_done    = s1_go && (s1_to_fifo ? !bus.fifo_full
                                             : out_can_load);

    assign bus.in_ready = !rst
                       && (!s1_valid || s1_done)
                       && (phase == PH_FIRST || !bus.fifo_empty);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.fifo_rd_en = accept && (phase != PH_FIRST);
    assign bus.fifo_wr_en = s1_go && s1_to_fifo && !bus.fifo_full;
    assign bus.fifo_din   = s1_sum;

    assign out_load = s1_go && !s1_to_fifo && out_can_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_phase <= PH_FIRST;
            s1_last  <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= bus.in_data;
                s1_phase <= phase;
                s1_last  <= col_wrap;
                col_cnt  <= col_wrap ? '0 : col_cnt + 1'b1;
                if (col_wrap) begin
                    row_cnt <= (row_cnt == RW'(K-1)) ? '0
                             : row_cnt + 1'b1;
                end
            end else if (s1_done) begin
                s1_valid <= 1'b0;
            end
        end
    end

    psum_out_reg #(
        .DATA_W (DATA_W)
    ) u_out (
        .clk      (clk),
        .rst      (rst),
        .load     (out_load),
        .din      (s1_sum),
        .last     (s1_last),
        .ready    (bus.out_ready),
        .can_load (out_can_load),
        .valid    (bus.out_valid),
        .data     (bus.out_data),
        .row_done (bus.row_done)
    );

endmodule

// File: tb/tb_psum_row_accum.sv
// Bench for psum_row_accum: queue-model FIFO with fault hooks,
// directed row stimulus and a scoreboard-driven output monitor.
module tb_psum_row_accum;

    import conv_pkg::*;

    typedef struct {
        logic signed [DATA_W-1:0] d;
        logic                     last;
    } exp_t;

    localparam logic signed [DATA_W-1:0] SAT_P  = 25'sd16777116;
    localparam logic signed [IN_W-1:0]   IN_MAX = 20'sd524287;
    localparam logic signed [IN_W-1:0]   IN_MIN = -20'sd524288;
    localparam logic signed [DATA_W-1:0] O_MAX  = 25'sd16777215;
    localparam logic signed [DATA_W-1:0] O_MIN  = -25'sd16777216;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    psum_row_accum_if #(.DATA_W(DATA_W), .IN_W(IN_W)) bus ();

    psum_row_accum #(
        .DATA_W  (DATA_W),
        .IN_W    (IN_W),
        .ROW_LEN (ROW_LEN),
        .K       (K),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    int   waits, bp_cnt, ff_cnt, bp_col, ff_col;
    int   bp_rdy, bp_pop, ff_wr;
    logic force_full;
    logic hook_clear, hook_sat, hook_fill;
    logic signed [DATA_W-1:0] hook_val;

    logic signed [DATA_W-1:0] fq[$];
    int   fcnt;

    assign bus.fifo_empty = (fcnt == 0);
    assign bus.fifo_full  = (fcnt >= ROW_LEN) || force_full;

    task automatic chk(input string name, input longint act,
                       input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // FIFO model: registered dout, pop before push in one cycle.
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            bus.fifo_dout <= '0;
            fcnt <= 0;
        end else begin
            if (hook_clear) fq.delete();
            if (hook_sat) begin
                foreach (fq[i]) fq[i] = (i % 2 == 0) ? SAT_P : -SAT_P;
            end
            if (hook_fill) begin
                for (int i = 0; i < ROW_LEN; i++) fq.push_back(hook_val);
            end
            if (bus.fifo_rd_en) begin
                if (fq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fifo_underflow: got pop expected none");
                end else begin
                    bus.fifo_dout <= fq.pop_front();
                end
            end
            if (bus.fifo_wr_en) begin
                if (fq.size() >= ROW_LEN) begin
                    checks++;
                    errors++;
                    $display("FAIL fifo_overflow: got push expected none");
                end else begin
                    fq.push_back(bus.fifo_din);
                end
            end
            fcnt <= fq.size();
        end
    end

    task automatic tick();
        @(negedge clk);
        if (bp_cnt > 0) begin
            bus.out_ready = 1'b0;
            bp_cnt--;
        end else begin
            bus.out_ready = 1'b1;
        end
        if (ff_cnt > 0) begin
            force_full = 1'b1;
            ff_cnt--;
        end else begin
            force_full = 1'b0;
        end
        #1;
        if (!bus.out_ready) begin
            if (bus.in_ready)   bp_rdy++;
            if (bus.fifo_rd_en) bp_pop++;
        end
        if (force_full && bus.fifo_wr_en) ff_wr++;
    endtask

    task automatic send(input logic signed [IN_W-1:0] d);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && w < 200) begin
            tick();
            w++;
        end
        if (w >= 200) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        waits += w;
        tick();
    endtask

    task automatic row(input logic signed [IN_W-1:0] ve,
                       input logic signed [IN_W-1:0] vo,
                       input bit last,
                       input logic signed [DATA_W-1:0] ee,
                       input logic signed [DATA_W-1:0] eo,
                       input int ncols);
        exp_t e;
        waits = 0;
        for (int c = 0; c < ncols; c++) begin
            if (c == bp_col) bp_cnt = 5;
            if (c == ff_col) ff_cnt = 3;
            if (last) begin
                e.d    = (c % 2 == 0) ? ee : eo;
                e.last = (c == ROW_LEN - 1);
                exp_q.push_back(e);
            end
            send((c % 2 == 0) ? ve : vo);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        bus.in_valid = 1'b0;
        while (exp_q.size() > 0 && w < 400) begin
            tick();
            w++;
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (3) tick();
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    logic signed [DATA_W-1:0] held;
    logic held_v = 1'b0;
    logic rd_pend = 1'b0;
    always begin
        logic rdf;
        exp_t e;
        @(negedge clk);
        #2;
        if (rst) begin
            held_v  = 1'b0;
            rd_pend = 1'b0;
        end else begin
            if (held_v) begin
                chk("out_hold_valid", bus.out_valid, 1);
                chk("out_hold_data", bus.out_data, held);
            end
            held_v = 1'b0;
            if (bus.out_valid) begin
                rdf = rd_pend | bus.row_done;
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected: got %0d expected none",
                                 bus.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", bus.out_data, e.d);
                        chk("row_done", rdf, e.last);
                    end
                    rd_pend = 1'b0;
                end else begin
                    rd_pend = rdf;
                    held    = bus.out_data;
                    held_v  = 1'b1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        force_full = 1'b0;
        hook_clear = 1'b0;
        hook_sat   = 1'b0;
        hook_fill  = 1'b0;
        hook_val   = '0;
        bp_cnt = 0; ff_cnt = 0; bp_col = -1; ff_col = -1;
        bp_rdy = 0; bp_pop = 0; ff_wr = 0;

        rst = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_row_done", bus.row_done, 0);
        chk("rst_fifo_wr_en", bus.fifo_wr_en, 0);
        chk("rst_fifo_rd_en", bus.fifo_rd_en, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        // Streaming 1,2,3 with no backpressure
        row(1, 1, 0, 0, 0, ROW_LEN);
        chk("stream_waits_r0", waits, 0);
        row(2, 2, 0, 0, 0, ROW_LEN);
        chk("stream_waits_r1", waits, 0);
        row(3, 3, 1, 6, 6, ROW_LEN);
        chk("stream_waits_r2", waits, 0);
        drain();
        chk("stream_fifo_empty", fcnt, 0);

        // FIFO-full stall in MID, output backpressure in LAST
        row(1, 1, 0, 0, 0, ROW_LEN);
        ff_col = 20;
        row(2, 2, 0, 0, 0, ROW_LEN);
        ff_col = -1;
        chk("ff_stall_cycles", waits, 3);
        chk("ff_wr_during_full", ff_wr, 0);
        bp_col = 30;
        row(3, 3, 1, 6, 6, ROW_LEN);
        bp_col = -1;
        chk("bp_stall_cycles", waits, 5);
        chk("bp_in_ready_high", bp_rdy, 0);
        chk("bp_pop_during_stall", bp_pop, 0);
        drain();
        chk("bp_fifo_empty", fcnt, 0);

        // Saturation against doctored delay-line words
        row(0, 0, 0, 0, 0, ROW_LEN);
        row(0, 0, 0, 0, 0, ROW_LEN);
        drain();
        hook_sat = 1'b1;
        tick();
        hook_sat = 1'b0;
        row(IN_MAX, IN_MIN, 1, O_MAX, O_MIN, ROW_LEN);
        drain();

        // Empty gating at the start of a MID row
        row(5, 5, 0, 0, 0, ROW_LEN);
        drain();
        hook_clear = 1'b1;
        tick();
        hook_clear = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 5;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gate_in_ready", bus.in_ready, 0);
            chk("gate_fifo_rd_en", bus.fifo_rd_en, 0);
        end
        hook_val  = 5;
        hook_fill = 1'b1;
        tick();
        hook_fill = 1'b0;
        chk("gate_in_ready_after_fill", bus.in_ready, 1);
        row(5, 5, 0, 0, 0, ROW_LEN);
        row(5, 5, 1, 15, 15, ROW_LEN);
        drain();

        // Reset in the middle of the MID row
        row(7, 7, 0, 0, 0, ROW_LEN);
        row(7, 7, 0, 0, 0, 30);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_data", bus.out_data, 0);
        chk("mid_rst_row_done", bus.row_done, 0);
        chk("mid_rst_fifo_wr_en", bus.fifo_wr_en, 0);
        chk("mid_rst_fifo_rd_en", bus.fifo_rd_en, 0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        row(5, 5, 0, 0, 0, ROW_LEN);
        row(5, 5, 0, 0, 0, ROW_LEN);
        row(5, 5, 1, 15, 15, ROW_LEN);
        drain();
        chk("final_fifo_empty", fcnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
